// File: rtl/axi_write_buffer.sv
// axi_write_buffer
//   Buffers register writes from the AXI4-Lite slave user port and forwards
//   them downstream as a first-word-fall-through valid/ready stream.
//   Optional status feature, enabled with macro AXI_WRITE_BUFFER_STATUS_EN:
//   local CTRL_ADDR decode, a 16-bit dequeue counter (done_cnt) and status
//   write-back into the slave readback RAM at STATUS_ADDR.
//   Reset is synchronous and active-high.

module axi_write_buffer #(
   parameter int unsigned DEPTH       = 16,
   parameter logic [31:0] STATUS_ADDR = 32'h0000_00FC,
   parameter logic [31:0] CTRL_ADDR   = 32'h0000_00F8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              write_addr,
   input  logic [31:0]              write_data,
   input  logic                     write_en,
   output logic                     user_ready,
   output logic [31:0]              m_addr,
   output logic [31:0]              m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [31:0]              update_addr,
   output logic [31:0]              update_data,
   output logic                     update_valid,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   logic [31:0]   mem_addr_q [DEPTH];
   logic [31:0]   mem_data_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;

   logic accept;
   logic is_ctrl;
   logic is_status;
   logic push;
   logic pop;

   // user_ready depends only on rst and registered occupancy, never on write_en.
   assign user_ready = !rst && (level_q < FULL_LEVEL);
   assign m_valid    = (level_q != '0);
   assign accept     = write_en && user_ready;
   assign push       = accept && !is_ctrl && !is_status;
   assign pop        = m_valid && m_ready;
   assign m_addr     = mem_addr_q[rd_ptr_q];
   assign m_data     = mem_data_q[rd_ptr_q];
   assign level      = level_q;

   // Next pointers and occupancy; a simultaneous push and pop leave level unchanged.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      // NOTE: state uses <= so every flop samples pre-edge values regardless of statement order.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Entry storage, written at the write pointer on push.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; an entry is only observed once level says it holds valid data.
      if (push) begin
         mem_addr_q[wr_ptr_q] <= write_addr;
         mem_data_q[wr_ptr_q] <= write_data;
      end
   end

`ifdef AXI_WRITE_BUFFER_STATUS_EN
   logic [15:0] done_cnt_q, done_cnt_d;
   logic        upd_valid_q, upd_valid_d;
   logic [31:0] upd_data_q, upd_data_d;
   logic        post_req;

   assign is_ctrl   = (write_addr == CTRL_ADDR);
   assign is_status = (write_addr == STATUS_ADDR);

   // Dequeue counter and status word; a control clear lands before a same-cycle dequeue counts.
   always_comb begin
      done_cnt_d  = done_cnt_q;
      upd_data_d  = upd_data_q;
      post_req    = (accept && is_ctrl) || pop;
      if (accept && is_ctrl && write_data[0]) done_cnt_d = '0;
      if (pop) done_cnt_d = done_cnt_d + 16'd1;
      upd_valid_d = post_req;
      if (post_req) upd_data_d = {16'(level_d), done_cnt_d};
   end

   // Status registers; reset drops any pending post.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_cnt_q  <= '0;
         upd_valid_q <= 1'b0;
         upd_data_q  <= '0;
      end else begin
         done_cnt_q  <= done_cnt_d;
         upd_valid_q <= upd_valid_d;
         upd_data_q  <= upd_data_d;
      end
   end

   assign update_addr  = STATUS_ADDR;
   assign update_data  = upd_data_q;
   assign update_valid = upd_valid_q;
`else
   // Without the status feature every address is plain FIFO traffic.
   logic unused_cfg;

   assign is_ctrl      = 1'b0;
   assign is_status    = 1'b0;
   assign update_addr  = '0;
   assign update_data  = '0;
   assign update_valid = 1'b0;
   assign unused_cfg   = ^{STATUS_ADDR, CTRL_ADDR};
`endif

endmodule
